// File: rtl/mem_ctrl_m1t_v2_pkg.sv
// Shared types and helpers for the M1T memory controller: modes, read types, FSM states, address decode.
// Latency: none (types and pure functions only).
// Backpressure: none.
package mem_ctrl_m1t_pkg;

    localparam logic [31:0] GPIO_BASE = 32'h800;

    typedef enum logic [1:0] {
        MODE_READ  = 2'd0,
        MODE_WRITE = 2'd1,
        MODE_FENCE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        DT_SBYTE  = 2'b00,
        DT_WORD_A = 2'b01,
        DT_UBYTE  = 2'b10,
        DT_WORD_B = 2'b11
    } dtype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fsm_state_e;

    typedef enum logic [1:0] {
        RG_RAM      = 2'd0,
        RG_GPO      = 2'd1,
        RG_GPI      = 2'd2,
        RG_UNMAPPED = 2'd3
    } region_e;

    typedef struct packed {
        region_e    region;
        logic [2:0] ch;
    } dec_t;

    // RAM takes priority; GPIO pairs sit at GPIO_BASE (even = GPO, odd = GPI).
    function automatic dec_t region_decode(input logic [31:0] a, input int ram_aw, input int gpio_ch);
        dec_t d;
        d.region = RG_UNMAPPED;
        d.ch     = 3'd0;
        if (a < (32'd1 << ram_aw)) begin
            d.region = RG_RAM;
        end else if (a >= GPIO_BASE && a < GPIO_BASE + 32'(2 * gpio_ch)) begin
            d.region = a[0] ? RG_GPI : RG_GPO;
            d.ch     = 3'((a - GPIO_BASE) >> 1);
        end
        return d;
    endfunction

    // Signed byte, unsigned byte or full word.
    function automatic logic [15:0] fmt_read(input dtype_e t, input logic [15:0] w);
        logic [15:0] r;
        case (t)
            DT_SBYTE: r = {{8{w[7]}}, w[7:0]};
            DT_UBYTE: r = {8'h00, w[7:0]};
            default:  r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl_m1t_v2_if.sv
// Core-side memory port of the M1T controller bundled as one interface.
// Latency: n/a (wiring only).
// Backpressure: core holds a request while core_mem_available is low.
interface mem_ctrl_m1t_v2_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] core_mem_address_out;
    logic [1:0]        core_mem_mask_out;
    logic [1:0]        core_mem_read_fnc_type;
    logic [15:0]       core_mem_data_out;
    logic [1:0]        core_mem_mode;
    logic              core_mem_enable;
    logic [3:0]        core_mem_wb_dest;
    logic              core_mem_input_ready;
    logic [15:0]       core_mem_data_in;
    logic [3:0]        core_mem_wb_dest_in;
    logic              core_mem_read_ack;
    logic              core_mem_available;
    logic              core_mem_idle;

    modport master (
        output core_mem_address_out, core_mem_mask_out, core_mem_read_fnc_type,
               core_mem_data_out, core_mem_mode, core_mem_enable, core_mem_wb_dest,
               core_mem_input_ready,
        input  core_mem_data_in, core_mem_wb_dest_in, core_mem_read_ack,
               core_mem_available, core_mem_idle
    );

    modport slave (
        input  core_mem_address_out, core_mem_mask_out, core_mem_read_fnc_type,
               core_mem_data_out, core_mem_mode, core_mem_enable, core_mem_wb_dest,
               core_mem_input_ready,
        output core_mem_data_in, core_mem_wb_dest_in, core_mem_read_ack,
               core_mem_available, core_mem_idle
    );
endinterface

// File: rtl/mem_ctrl_m1t_v2_ram.sv
// Two 8-bit lanes of 2^AW words with per-lane write enables and a registered read port.
// Latency: 1 cycle read (data valid after the enabling edge), writes land at the edge.
// Backpressure: none; the read register holds while re_i is low.
module m1t_bytelane_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);
    logic [7:0]  lane0_q [0:(1<<AW)-1];
    logic [7:0]  lane1_q [0:(1<<AW)-1];
    logic [15:0] rdata_q;

    // Lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i[0]) lane0_q[addr_i] <= wdata_i[7:0];
        if (we_i[1]) lane1_q[addr_i] <= wdata_i[15:8];
    end

    // Read register captures only on a read so data stays put through wait-states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata_q <= 16'h0000;
        else if (re_i) rdata_q <= {lane1_q[addr_i], lane0_q[addr_i]};
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_ctrl_m1t_v2.sv
// M1T memory controller: RAM + GPIO behind the core port, request FSM with optional read wait-states.
// Latency: read_ack WAIT_STATES+1 clk_en cycles after accept; writes/fences commit at accept.
// Backpressure: available drops outside IDLE; clk_en low freezes everything.
module mem_ctrl_m1t_v2
    import mem_ctrl_m1t_pkg::*;
#(
    parameter int          ADDR_W      = 15,
    parameter int          RAM_AW      = 11,
    parameter int          GPIO_CH     = 2,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] GPO_RESET   = 16'h0000
) (
    input  logic                   clk,
    input  logic                   async_rst,
    input  logic                   clk_en,
    mem_ctrl_m1t_v2_if.slave       bus,
    output logic [16*GPIO_CH-1:0]  gpo_bank,
    input  logic [16*GPIO_CH-1:0]  gpi_bank
);
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [2:0] WS_LOAD  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    fsm_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [GPIO_CH-1:0][15:0] gpo_q;
    logic [GPIO_CH-1:0][15:0] gpi_s1_q, gpi_s2_q;

    logic        rd_pend_q;
    dtype_e      dtype_q;
    logic [3:0]  tag_q;
    region_e     region_q;
    logic [15:0] io_word_q;
    logic [15:0] data_hold_q;
    logic [3:0]  wb_hold_q;

    dec_t        dec;
    logic        accept, is_read, is_write;
    logic [15:0] io_word, ram_rdata, resp_data;
    logic [1:0]  ram_we;

    assign dec      = region_decode(32'(bus.core_mem_address_out), RAM_AW, GPIO_CH);
    assign accept   = clk_en && bus.core_mem_enable && bus.core_mem_input_ready && (state_q == ST_IDLE);
    assign is_read  = (bus.core_mem_mode == MODE_READ);
    assign is_write = (bus.core_mem_mode == MODE_WRITE);
    assign ram_we   = {2{accept && is_write && dec.region == RG_RAM}} & bus.core_mem_mask_out;

    m1t_bytelane_ram #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .rst     (async_rst),
        .we_i    (ram_we),
        .re_i    (accept && is_read && dec.region == RG_RAM),
        .addr_i  (bus.core_mem_address_out[RAM_AW-1:0]),
        .wdata_i (bus.core_mem_data_out),
        .rdata_o (ram_rdata)
    );

    // GPIO word selected by the current request; unmapped and RAM give 0 here.
    always_comb begin
        io_word = 16'h0000;
        for (int k = 0; k < GPIO_CH; k++) begin
            if (dec.ch == 3'(k)) begin
                if (dec.region == RG_GPO) io_word = gpo_q[k];
                if (dec.region == RG_GPI) io_word = gpi_s2_q[k];
            end
        end
    end

    // GPO channels: byte-masked writes at the accept edge.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int k = 0; k < GPIO_CH; k++) gpo_q[k] <= GPO_RESET;
        end else if (accept && is_write && dec.region == RG_GPO) begin
            for (int k = 0; k < GPIO_CH; k++) begin
                if (dec.ch == 3'(k)) begin
                    if (bus.core_mem_mask_out[0]) gpo_q[k][7:0]  <= bus.core_mem_data_out[7:0];
                    if (bus.core_mem_mask_out[1]) gpo_q[k][15:8] <= bus.core_mem_data_out[15:8];
                end
            end
        end
    end

    // Two-flop GPI synchroniser, frozen with clk_en.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            gpi_s1_q <= '0;
            gpi_s2_q <= '0;
        end else if (clk_en) begin
            gpi_s1_q <= gpi_bank;
            gpi_s2_q <= gpi_s1_q;
        end
    end

    // Request context captured at accept so the response is independent of later bus activity.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            rd_pend_q <= 1'b0;
            dtype_q   <= DT_SBYTE;
            tag_q     <= 4'h0;
            region_q  <= RG_UNMAPPED;
            io_word_q <= 16'h0000;
        end else if (accept) begin
            rd_pend_q <= is_read;
            dtype_q   <= dtype_e'(bus.core_mem_read_fnc_type);
            tag_q     <= bus.core_mem_wb_dest;
            region_q  <= dec.region;
            io_word_q <= io_word;
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: reads end in RESP, writes/fences return to IDLE after any wait-states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else if (is_read) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (clk_en) begin
                    if (cnt_q == 3'd0) state_d = rd_pend_q ? ST_RESP : ST_IDLE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (clk_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_data = fmt_read(dtype_q, (region_q == RG_RAM) ? ram_rdata : io_word_q);

    // Response values latched as RESP retires so the outputs hold between responses.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            data_hold_q <= 16'h0000;
            wb_hold_q   <= 4'h0;
        end else if (state_q == ST_RESP && clk_en) begin
            data_hold_q <= resp_data;
            wb_hold_q   <= tag_q;
        end
    end

    assign bus.core_mem_read_ack   = (state_q == ST_RESP);
    assign bus.core_mem_available  = (state_q == ST_IDLE);
    assign bus.core_mem_idle       = (state_q == ST_IDLE);
    assign bus.core_mem_data_in    = (state_q == ST_RESP) ? resp_data : data_hold_q;
    assign bus.core_mem_wb_dest_in = (state_q == ST_RESP) ? tag_q : wb_hold_q;
    assign gpo_bank                = gpo_q;
endmodule

// File: doc/mem_ctrl_m1t_v2.md
# mem_ctrl_m1t_v2

Parametrised second-generation memory controller for the M1T SoC. It sits between the M1 core's memory port and on-chip resources: a byte-lane RAM of configurable depth and N memory-mapped 16-bit GPIO channels. Over the first generation it adds:
- configurable read wait-states under a request FSM;
- GPO readback;
- synchronised GPI;
- fence handling;
- defined responses for unmapped accesses.

## Interface
Parameters:
- ADDR_W, 15, core word-address width
- RAM_AW, 11, RAM address bits (RAM_AW+1 ≤ ADDR_W); RAM holds 2^RAM_AW words
- GPIO_CH, 2, number of GPIO channels (1..8)
- WAIT_STATES, 0, extra read latency cycles (0..7)
- GPO_RESET, 16'h0000, reset value of every GPO channel

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- async_rst  in  1  asynchronous active-high reset
- clk_en  in  1  global advance enable; when low, all state holds
- core_mem_address_out  in  ADDR_W  word address
- core_mem_mask_out  in  2  byte enables: bit0 = [7:0], bit1 = [15:8]
- core_mem_read_fnc_type  in  2  read type: 00 signed byte, 10 unsigned byte, else word
- core_mem_data_out  in  16  write data
- core_mem_mode  in  2  0 read, 1 write, 2/3 fence
- core_mem_enable  in  1  request valid
- core_mem_wb_dest  in  4  writeback register tag
- core_mem_input_ready  in  1  core qualifier for request
- core_mem_data_in  out  16  read response data
- core_mem_wb_dest_in  out  4  tag echoed with response
- core_mem_read_ack  out  1  one-cycle response strobe
- core_mem_available  out  1  controller can accept a request
- core_mem_idle  out  1  no access in flight
- gpo_bank  out  16*GPIO_CH  GPO channels; channel k occupies [16k+15:16k]
- gpi_bank  in  16*GPIO_CH  asynchronous GPI inputs

## Operation

**Accept condition.** A request is accepted on a rising edge where clk_en && core_mem_enable && core_mem_input_ready && core_mem_available.

**Address map (word address A).**
- A < 2^RAM_AW: RAM.
- A = 0x800+2k (k < GPIO_CH): GPO channel k, read/write.
- A = 0x800+2k+1: GPI channel k, read-only; writes are dropped.
- Anything else is unmapped: writes are dropped, reads return 0x0000.

**Writes.**
- Committed at the accept edge.
- Byte lanes follow the mask; mask 00 is a no-op.

**Read data formatting.** The selected 16-bit word is formatted by type:
- 00: sign-extend [7:0].
- 10: zero-extend [7:0].
- 01/11: full word.

**GPI synchronisation.** gpi_bank passes through a 2-flop synchroniser per bit. Reads return the synchronised value.

**Fence.** Accepted like a request. Produces no read_ack and occupies the FSM exactly as a write does.

**FSM states.**
- IDLE: available=1, idle=1.
  - Read accepted: go to WAIT if WAIT_STATES>0, else RESP.
  - Write or fence accepted: go to WAIT if WAIT_STATES>0, else stay in IDLE.
- WAIT: available=0, idle=0. Counter loads WAIT_STATES−1 and decrements on clk_en.
  - At 0: reads go to RESP; writes/fences go to IDLE.
- RESP: available=0, idle=0. read_ack=1 for one cycle; data_in and wb_dest_in update. Next state is IDLE.

**Output holding.** data_in and wb_dest_in hold their values between responses.

## Timing
- **Reset values:**
  - state IDLE;
  - read_ack 0;
  - data_in 16'h0000;
  - wb_dest_in 4'h0;
  - available 1;
  - idle 1;
  - every GPO channel GPO_RESET;
  - synchroniser flops 0.
- **Read latency:** accepted at edge N, read_ack is high during cycle N+1+WAIT_STATES, counted in clk_en-qualified cycles.
- **RAM read point:** RAM is read at the accept edge, so data reflects all writes accepted earlier.
- **GPI read point:** GPI is sampled at the accept edge, i.e. it is 2 cycles stale relative to the pin.
- **Back-to-back throughput:** with WAIT_STATES=0, writes and fences are accepted every cycle, and reads every 2 cycles.
- **Stalls:**
  - clk_en low freezes the FSM, counter, read_ack level and the synchroniser.
  - A request presented while available=0 is ignored; the core holds it.
- **Async reset mid-access:** aborts the access. A write already committed at its accept edge persists in RAM; RAM contents are not reset.

## Structure
- **Package mem_ctrl_m1t_pkg:**
  - mode enum (READ, WRITE, FENCE);
  - dtype enum;
  - FSM state enum;
  - GPIO_BASE = 'h800;
  - region-decode function returning {RAM, GPO, GPI, UNMAPPED} plus the channel index.
- **Sub-module m1t_bytelane_ram:**
  - two 8-bit-wide arrays of depth 2^RAM_AW;
  - per-lane write enable;
  - registered read.

## Test plan
1. Reset, then a word write to 0x0010 of 0xA5F0 with mask 11, then a word read of 0x0010 -> read_ack exactly 1+WAIT_STATES cycles later, data_in=0xA5F0, wb_dest_in equals the request tag.
2. Write 0x12FF with mask 01 to 0x0020, then read 0x0020 as type 00 and then as type 10 -> data_in=0xFFFF, then 0x00FF; the upper byte stays at its prior value.
3. Write 0xBEEF to 0x802 (GPO ch1) -> gpo_bank[31:16]=0xBEEF on the next cycle. Read 0x802 -> 0xBEEF. Drive gpi_bank[15:0]=0x1234 and read 0x801 after 2 cycles -> 0x1234.
4. Read an unmapped address (0x1000) -> read_ack pulses with data 0x0000. A write there -> RAM and GPO unchanged.
5. WAIT_STATES=3: issue a read with clk_en deasserted for 2 cycles mid-WAIT -> ack is delayed by exactly 2 cycles; available stays 0 throughout; a second request held during this time is accepted only after RESP.
6. Assert async_rst during the WAIT state of a read -> outputs take their reset values immediately, no read_ack appears, and GPO returns to GPO_RESET.
